// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions.
// Writeback select codes, load funct3 codes, writeback FSM states.
package riscv_pkg;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMMIT,
    S_WAIT_LOAD
  } wb_state_t;

endpackage

// File: rtl/load_formatter.sv
// Load data formatter.
// Picks the byte/halfword lane and applies sign or zero extension.
module load_formatter
  import riscv_pkg::*;
(
  input  logic [31:0] LoadData,
  input  logic [2:0]  Funct3,
  input  logic [1:0]  AddrLo,
  output logic [31:0] Result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = LoadData[7:0];
    case (AddrLo)
      2'd1:    byte_sel = LoadData[15:8];
      2'd2:    byte_sel = LoadData[23:16];
      2'd3:    byte_sel = LoadData[31:24];
      default: byte_sel = LoadData[7:0];
    endcase
  end

  // Halfword alignment is guaranteed upstream.
  assign half_sel = AddrLo[1] ? LoadData[31:16]
                              : LoadData[15:0];

  always_comb begin
    Result = LoadData;
    case (Funct3)
      F3_LB:   Result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  Result = {24'd0, byte_sel};
      F3_LH:   Result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  Result = {16'd0, half_sel};
      default: Result = LoadData;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: commits one instruction per cycle to the
// register file, stalling on loads until memory responds.
module wb_stage
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic             InRegWEn,
  input  logic [4:0]       InRd,
  input  logic [1:0]       InWbSel,
  input  logic [2:0]       InFunct3,
  input  logic [1:0]       InAddrLo,
  input  logic [31:0]      InAluResult,
  input  logic [31:0]      InPcPlus4,
  input  logic             LoadValid,
  input  logic [31:0]      LoadData,
  output logic             RegWEn,
  output logic [4:0]       WriteReg,
  output logic [31:0]      RegWriteData,
  output logic [CNT_W-1:0] RetireCount,
  output logic             Busy
);

  wb_state_t        state_q, state_d;
  logic [4:0]       pend_rd_q, pend_rd_d;
  logic             pend_wen_q, pend_wen_d;
  logic [2:0]       pend_f3_q, pend_f3_d;
  logic [1:0]       pend_lo_q, pend_lo_d;
  logic             wen_q, wen_d;
  logic [4:0]       wr_q, wr_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      ld_fmt;
  logic             xfer;

  load_formatter u_fmt (
    .LoadData (LoadData),
    .Funct3   (pend_f3_q),
    .AddrLo   (pend_lo_q),
    .Result   (ld_fmt)
  );

  assign InReady = (state_q != S_WAIT_LOAD);
  assign xfer    = InValid && InReady;

  always_comb begin
    state_d    = state_q;
    pend_rd_d  = pend_rd_q;
    pend_wen_d = pend_wen_q;
    pend_f3_d  = pend_f3_q;
    pend_lo_d  = pend_lo_q;
    wen_d      = 1'b0;
    wr_d       = wr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_WAIT_LOAD: begin
        if (LoadValid) begin
          state_d = S_COMMIT;
          wen_d   = pend_wen_q && (pend_rd_q != 5'd0);
          wr_d    = pend_rd_q;
          data_d  = ld_fmt;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (!xfer) begin
          state_d = S_IDLE;
        end else if (InWbSel == WB_LOAD) begin
          state_d    = S_WAIT_LOAD;
          pend_rd_d  = InRd;
          pend_wen_d = InRegWEn;
          pend_f3_d  = InFunct3;
          pend_lo_d  = InAddrLo;
        end else begin
          state_d = S_COMMIT;
          wen_d   = InRegWEn && (InRd != 5'd0);
          wr_d    = InRd;
          data_d  = (InWbSel == WB_PC4) ? InPcPlus4
                                        : InAluResult;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pend_rd_q  <= '0;
      pend_wen_q <= 1'b0;
      pend_f3_q  <= '0;
      pend_lo_q  <= '0;
      wen_q      <= 1'b0;
      wr_q       <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_rd_q  <= pend_rd_d;
      pend_wen_q <= pend_wen_d;
      pend_f3_q  <= pend_f3_d;
      pend_lo_q  <= pend_lo_d;
      wen_q      <= wen_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign RegWEn       = wen_q;
  assign WriteReg     = wr_q;
  assign RegWriteData = data_q;
  assign RetireCount  = cnt_q;
  assign Busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: transaction-level model compared every
// cycle, plus directed literal expectations.
module tb_wb_stage;
  import riscv_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic          InRegWEn = 1'b0;
  logic [4:0]    InRd = '0;
  logic [1:0]    InWbSel = '0;
  logic [2:0]    InFunct3 = '0;
  logic [1:0]    InAddrLo = '0;
  logic [31:0]   InAluResult = '0;
  logic [31:0]   InPcPlus4 = '0;
  logic          LoadValid = 1'b0;
  logic [31:0]   LoadData = '0;
  logic          RegWEn;
  logic [4:0]    WriteReg;
  logic [31:0]   RegWriteData;
  logic [CW-1:0] RetireCount;
  logic          Busy;

  wb_stage #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .InValid      (InValid),
    .InReady      (InReady),
    .InRegWEn     (InRegWEn),
    .InRd         (InRd),
    .InWbSel      (InWbSel),
    .InFunct3     (InFunct3),
    .InAddrLo     (InAddrLo),
    .InAluResult  (InAluResult),
    .InPcPlus4    (InPcPlus4),
    .LoadValid    (LoadValid),
    .LoadData     (LoadData),
    .RegWEn       (RegWEn),
    .WriteReg     (WriteReg),
    .RegWriteData (RegWriteData),
    .RetireCount  (RetireCount),
    .Busy         (Busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Arithmetic view of load formatting.
  function automatic logic [31:0] fmt(input logic [31:0] d,
                                      input logic [2:0] f3,
                                      input logic [1:0] lo);
    longint unsigned v;
    longint signed s;
    case (f3)
      3'b000, 3'b100: begin
        v = (longint'(d) >> (8 * int'(lo))) % 256;
        s = (f3 == 3'b000 && v >= 128) ? longint'(v) - 256
                                       : longint'(v);
      end
      3'b001, 3'b101: begin
        v = (longint'(d) >> (16 * (int'(lo) / 2))) % 65536;
        s = (f3 == 3'b001 && v >= 32768) ? longint'(v) - 65536
                                         : longint'(v);
      end
      default: s = longint'(d);
    endcase
    return s[31:0];
  endfunction

  bit          m_pend = 0;
  bit          m_commit = 0;
  logic [4:0]  p_rd = '0;
  logic        p_wen = 1'b0;
  logic [2:0]  p_f3 = '0;
  logic [1:0]  p_lo = '0;
  logic        m_wen = 1'b0;
  logic [4:0]  m_wr = '0;
  logic [31:0] m_data = '0;
  int          m_retired = 0;

  task automatic retire(input logic wen, input logic [4:0] rd,
                        input logic [31:0] v);
    m_commit  = 1;
    m_wen     = wen && (rd != 0);
    m_wr      = rd;
    m_data    = v;
    m_retired = m_retired + 1;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend = 0; m_commit = 0; m_wen = 0;
      m_wr = '0; m_data = '0; m_retired = 0;
    end else begin
      m_commit = 0;
      m_wen    = 0;
      if (m_pend) begin
        if (LoadValid) begin
          m_pend = 0;
          retire(p_wen, p_rd, fmt(LoadData, p_f3, p_lo));
        end
      end else if (InValid) begin
        if (InWbSel == WB_LOAD) begin
          m_pend = 1;
          p_rd = InRd; p_wen = InRegWEn;
          p_f3 = InFunct3; p_lo = InAddrLo;
        end else begin
          retire(InRegWEn, InRd,
                 InWbSel == WB_PC4 ? InPcPlus4 : InAluResult);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_RegWEn", 32'(RegWEn), 32'(m_wen));
    chk("m_WriteReg", 32'(WriteReg), 32'(m_wr));
    chk("m_RegWriteData", RegWriteData, m_data);
    chk("m_RetireCount", 32'(RetireCount),
        32'(m_retired % (1 << CW)));
    chk("m_Busy", 32'(Busy), 32'(m_pend || m_commit));
    chk("m_InReady", 32'(InReady), 32'(!m_pend));
  end

  task automatic step;
    @(posedge clk); #2;
  endtask

  task automatic send(input logic [1:0] sel, input logic [4:0] rd,
                      input logic wen, input logic [2:0] f3,
                      input logic [1:0] lo, input logic [31:0] alu,
                      input logic [31:0] pc4);
    InValid = 1; InWbSel = sel; InRd = rd; InRegWEn = wen;
    InFunct3 = f3; InAddrLo = lo;
    InAluResult = alu; InPcPlus4 = pc4;
    step();
    InValid = 0;
  endtask

  task automatic do_load(input string nm, input logic [2:0] f3,
                         input logic [1:0] lo, input logic [31:0] d,
                         input logic [4:0] rd, input int dly,
                         input logic [31:0] exp);
    int low = 0;
    LoadData = d;
    send(WB_LOAD, rd, 1'b1, f3, lo, 32'hDEAD0000, 32'hDEAD0004);
    for (int i = 0; i < dly; i++) begin
      if (i == dly - 1) LoadValid = 1;
      @(negedge clk);
      if (!InReady) low++;
      step();
    end
    LoadValid = 0;
    @(negedge clk);
    chk({nm, "_data"}, RegWriteData, exp);
    chk({nm, "_wen"}, 32'(RegWEn), 32'd1);
    chk({nm, "_rd"}, 32'(WriteReg), 32'(rd));
    chk({nm, "_ready_low"}, 32'(low), 32'(dly));
    step();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wen", 32'(RegWEn), 32'd0);
    chk("rst_wr", 32'(WriteReg), 32'd0);
    chk("rst_data", RegWriteData, 32'd0);
    chk("rst_cnt", 32'(RetireCount), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_ready", 32'(InReady), 32'd1);
    step();
    rst = 1;
    step();

    send(WB_ALU, 5'd5, 1'b1, 3'd0, 2'd0, 32'hA5A5A5A5, 32'h4);
    @(negedge clk);
    chk("alu5_wen", 32'(RegWEn), 32'd1);
    chk("alu5_rd", 32'(WriteReg), 32'd5);
    chk("alu5_data", RegWriteData, 32'hA5A5A5A5);
    chk("alu5_cnt", 32'(RetireCount), 32'd1);
    step();

    send(WB_ALU, 5'd0, 1'b1, 3'd0, 2'd0, 32'h12345678, 32'h8);
    @(negedge clk);
    chk("x0_wen", 32'(RegWEn), 32'd0);
    chk("x0_cnt", 32'(RetireCount), 32'd2);
    step();

    send(2'd3, 5'd3, 1'b0, 3'd0, 2'd0, 32'h0000CAFE, 32'hC);
    @(negedge clk);
    chk("nowen_wen", 32'(RegWEn), 32'd0);
    step();

    LoadValid = 1;
    step();
    LoadValid = 0;
    step();

    do_load("lb", F3_LB, 2'd2, 32'h0080FF00, 5'd7, 3, 32'hFFFFFF80);
    do_load("lbu", F3_LBU, 2'd2, 32'h0080FF00, 5'd8, 3, 32'h00000080);
    do_load("lhu", F3_LHU, 2'd0, 32'h1234ABCD, 5'd13, 1, 32'h0000ABCD);
    do_load("lw", F3_LW, 2'd1, 32'h87654321, 5'd14, 2, 32'h87654321);
    do_load("f3_7", 3'b111, 2'd3, 32'h80FF7F01, 5'd15, 1, 32'h80FF7F01);
    do_load("lb3", F3_LB, 2'd3, 32'h7F000000, 5'd16, 1, 32'h0000007F);

    LoadData = 32'h80017FFF;
    send(WB_LOAD, 5'd6, 1'b1, F3_LH, 2'd3, 32'h0, 32'h0);
    LoadValid = 1;
    step();
    LoadValid = 0;
    InValid = 1; InWbSel = WB_ALU; InRd = 5'd9; InRegWEn = 1;
    InAluResult = 32'h0BADF00D;
    @(negedge clk);
    chk("lh_data", RegWriteData, 32'hFFFF8001);
    chk("lh_ready", 32'(InReady), 32'd1);
    step();
    InValid = 0;
    @(negedge clk);
    chk("after_ld_data", RegWriteData, 32'h0BADF00D);
    chk("after_ld_rd", 32'(WriteReg), 32'd9);
    step();

    InValid = 1; InWbSel = WB_ALU; InRd = 5'd10; InRegWEn = 1;
    InAluResult = 32'hDCDCDCDC;
    step();
    InWbSel = WB_PC4; InRd = 5'd11; InPcPlus4 = 32'h00001004;
    InAluResult = 32'hFFFFFFFF;
    @(negedge clk);
    chk("b2b0_wen", 32'(RegWEn), 32'd1);
    chk("b2b0_rd", 32'(WriteReg), 32'd10);
    chk("b2b0_data", RegWriteData, 32'hDCDCDCDC);
    step();
    InValid = 0;
    @(negedge clk);
    chk("b2b1_wen", 32'(RegWEn), 32'd1);
    chk("b2b1_rd", 32'(WriteReg), 32'd11);
    chk("b2b1_data", RegWriteData, 32'h00001004);
    step();
    @(negedge clk);
    chk("hold_wen", 32'(RegWEn), 32'd0);
    chk("hold_data", RegWriteData, 32'h00001004);
    step();

    LoadData = 32'h11223344;
    send(WB_LOAD, 5'd12, 1'b1, F3_LW, 2'd0, 32'h0, 32'h0);
    step();
    #1 rst = 0;
    #1;
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_ready", 32'(InReady), 32'd1);
    chk("mid_rst_cnt", 32'(RetireCount), 32'd0);
    step();
    rst = 1;
    LoadValid = 1;
    step();
    LoadValid = 0;
    @(negedge clk);
    chk("drop_wen", 32'(RegWEn), 32'd0);
    chk("drop_cnt", 32'(RetireCount), 32'd0);
    step();

    InValid = 1; InWbSel = WB_ALU; InRegWEn = 1;
    for (int i = 0; i < 15; i++) begin
      InRd = 5'(i + 1);
      InAluResult = 32'(i * 3);
      step();
    end
    InRd = 5'd20;
    step();
    InValid = 0;
    @(negedge clk);
    chk("wrap_cnt", 32'(RetireCount), 32'd0);
    chk("wrap_rd", 32'(WriteReg), 32'd20);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RISC-V core. It accepts one retiring instruction per handshake from the memory stage and waits for the memory response when the instruction is a load. It formats load data by width and sign, then drives the register file write port (`RegWEn`, `WriteReg`, `RegWriteData`) for exactly one cycle per committed instruction. It also keeps a retired-instruction counter.

## Interface
Parameters:
- `CNT_W`, default 32: width of `RetireCount`.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous assertion, active-low (0 = reset).
- `InValid`  in  1  memory stage presents an instruction.
- `InReady`  out  1  stage can accept; the transfer happens when `InValid && InReady`.
- `InRegWEn`  in  1  instruction writes a destination register.
- `InRd`  in  5  destination register index.
- `InWbSel`  in  2  writeback source: 0 ALU, 1 LOAD, 2 PC+4, 3 reserved (treated as ALU).
- `InFunct3`  in  3  load type.
- `InAddrLo`  in  2  byte offset of the load address.
- `InAluResult`  in  32  ALU result.
- `InPcPlus4`  in  32  link value.
- `LoadValid`  in  1  memory response valid.
- `LoadData`  in  32  raw aligned memory word.
- `RegWEn`  out  1  register file write enable.
- `WriteReg`  out  5  register file write index.
- `RegWriteData`  out  32  register file write data.
- `RetireCount`  out  `CNT_W`  instructions committed since reset.
- `Busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, COMMIT, WAIT_LOAD.
- From IDLE or COMMIT:
  - On transfer with `InWbSel` = LOAD, go to WAIT_LOAD and latch `InRd`, `InRegWEn`, `InFunct3`, `InAddrLo`.
  - On transfer with any other `InWbSel`, go to COMMIT. Latch the result: `InAluResult` for ALU or reserved, `InPcPlus4` for PC+4.
  - With no transfer, go to IDLE.
- WAIT_LOAD: `LoadValid` = 1 latches the formatted `LoadData` and moves to COMMIT. Otherwise the stage stays in WAIT_LOAD. `LoadValid` is ignored in every other state.
- `InReady` = (state != WAIT_LOAD). It is combinational from state only and never depends on `InValid`.
- COMMIT lasts one cycle.
  - `RegWEn` = latched `InRegWEn` && (latched rd != 0).
  - `WriteReg` and `RegWriteData` present the latched values.
  - `RetireCount` increments by 1. This happens even when the write is suppressed (rd = 0 or `InRegWEn` = 0).
- `RetireCount` wraps modulo 2^`CNT_W`.
- Load formatting, byte lane selected by `InAddrLo`:
  - 000 LB: sign-extend `LoadData[8*AddrLo +: 8]`.
  - 100 LBU: zero-extend the same byte.
  - 001 LH: sign-extend `LoadData[16*AddrLo[1] +: 16]`; `AddrLo[0]` is ignored because alignment is checked upstream.
  - 101 LHU: zero-extend the same halfword.
  - 010 LW and all other codes: the full word.
- Outside COMMIT: `RegWEn` = 0, while `WriteReg` and `RegWriteData` hold their last values.

## Timing
- Reset values: state IDLE, `RegWEn` 0, `WriteReg` 0, `RegWriteData` 0, `RetireCount` 0, `Busy` 0. During and after reset `InReady` = 1.
- Non-load: transfer at edge N puts COMMIT in cycle N+1, and the register file writes at edge N+2. Back-to-back transfers sustain 1 instruction/cycle.
- Load: transfer at edge N puts the stage in WAIT_LOAD from cycle N+1. The earliest `LoadValid` is in cycle N+1, giving COMMIT in N+2. Each extra wait cycle adds one cycle of latency.
- `LoadValid` asserted together with the load's own transfer is ignored; the response must come at least one cycle later.
- A new transfer is accepted in the COMMIT cycle that follows a load.
- Reset asserted mid-operation: the stage returns immediately to reset values. The pending load is dropped and produces no write.
- `RegWEn` is never high for two consecutive cycles for the same instruction.

## Structure
- `riscv_pkg`:
  - `WB_ALU`, `WB_LOAD`, `WB_PC4` encodings.
  - Load funct3 constants `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
  - State enum `wb_state_t`.
- Sub-module `load_formatter`: combinational; inputs `LoadData`, funct3, `AddrLo`; output is the 32-bit formatted value.
- `wb_stage` holds the FSM, the latches, the counter and the output registers.

## Test plan
- Reset with `rst` = 0, then release → all outputs 0, `InReady` = 1, `Busy` = 0.
- ALU transfer with rd = 5, value 32'hA5A5A5A5 → one cycle later `RegWEn` = 1, `WriteReg` = 5, `RegWriteData` = A5A5A5A5, `RetireCount` = 1.
- ALU transfer with rd = 0, value 32'h12345678 → `RegWEn` stays 0 and `RetireCount` still increments.
- LB with `AddrLo` = 2, `LoadData` = 32'h0080FF00, `LoadValid` delayed 3 cycles → `InReady` low for 3 cycles, then `RegWriteData` = FFFFFF80. The same stimulus with LBU → 00000080.
- Back-to-back ALU transfers to rd = 10 (32'hDCDCDCDC) then rd = 11 → `RegWEn` high for 2 consecutive cycles with the matching indices and data.
- Reset asserted in WAIT_LOAD, then `LoadValid` pulsed → no write occurs and `RetireCount` = 0.
